// File: rtl/mask_filter_stage.sv
// RGB -> 1-bit threshold mask with optional 3-tap horizontal morphology.
// Emits the mask alongside the delay-matched camera pixel and coordinates.
module mask_filter_stage #(
    parameter int H_ACTIVE = 1280,
    parameter int HCOUNT_W = 11,
    parameter int VCOUNT_W = 10
) (
    input  logic                clk_pixel,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic [23:0]         pixel_in,
    input  logic [1:0]          channel_sel_in,
    input  logic [7:0]          lower_in,
    input  logic [7:0]          upper_in,
    input  logic [1:0]          filter_mode_in,
    output logic                valid_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic [23:0]         pixel_out,
    output logic                mask_out
);
    localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);

    logic [1:0]          r_cfg_ch, r_cfg_mode;
    logic [7:0]          r_cfg_lo, r_cfg_hi;
    logic                w_fs;
    logic [1:0]          w_ch_sel, w_mode;
    logic [7:0]          w_lo, w_hi, w_ch;
    logic [15:0]         w_luma_sum;

    logic [1:0]          r_vld_pipe;
    logic [23:0]         r1_pix, r2_pix;
    logic [HCOUNT_W-1:0] r1_h, r2_h;
    logic [VCOUNT_W-1:0] r1_v, r2_v;
    logic [7:0]          r1_ch, r1_lo, r1_hi;
    logic [1:0]          r1_mode, r2_mode;
    logic                r2_raw;

    logic                r_c_vld, r_l_raw, r_c_raw, r_flush;
    logic [23:0]         r_c_pix;
    logic [HCOUNT_W-1:0] r_c_h;
    logic [VCOUNT_W-1:0] r_c_v;
    logic [1:0]          r_c_mode;
    logic                w_emit, w_r, w_mask;

    // The frame-start beat itself already uses the freshly presented config.
    assign w_fs     = valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign w_ch_sel = w_fs ? channel_sel_in : r_cfg_ch;
    assign w_mode   = w_fs ? filter_mode_in : r_cfg_mode;
    assign w_lo     = w_fs ? lower_in : r_cfg_lo;
    assign w_hi     = w_fs ? upper_in : r_cfg_hi;

    assign w_luma_sum = 16'd77  * {8'd0, pixel_in[23:16]}
                      + 16'd150 * {8'd0, pixel_in[15:8]}
                      + 16'd29  * {8'd0, pixel_in[7:0]};

    always_comb begin
        w_ch = w_luma_sum[15:8];
        case (w_ch_sel)
            2'b00:   w_ch = pixel_in[23:16];
            2'b01:   w_ch = pixel_in[15:8];
            2'b10:   w_ch = pixel_in[7:0];
            default: w_ch = w_luma_sum[15:8];
        endcase
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            r_cfg_ch   <= 2'b00;
            r_cfg_mode <= 2'b00;
            r_cfg_lo   <= 8'd0;
            r_cfg_hi   <= 8'd255;
        end else if (w_fs) begin
            r_cfg_ch   <= channel_sel_in;
            r_cfg_mode <= filter_mode_in;
            r_cfg_lo   <= lower_in;
            r_cfg_hi   <= upper_in;
        end
    end

    // Thresholds and mode travel with each beat so a frame switch lands exactly at (0,0).
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            r_vld_pipe <= '0;
            r1_pix <= '0; r1_h <= '0; r1_v <= '0;
            r1_ch <= '0; r1_lo <= '0; r1_hi <= '0; r1_mode <= '0;
            r2_pix <= '0; r2_h <= '0; r2_v <= '0; r2_raw <= 1'b0; r2_mode <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], valid_in};
            r1_pix  <= pixel_in;
            r1_h    <= hcount_in;
            r1_v    <= vcount_in;
            r1_ch   <= w_ch;
            r1_lo   <= w_lo;
            r1_hi   <= w_hi;
            r1_mode <= w_mode;
            r2_pix  <= r1_pix;
            r2_h    <= r1_h;
            r2_v    <= r1_v;
            r2_mode <= r1_mode;
            r2_raw  <= (r1_lo <= r1_ch) && (r1_ch <= r1_hi);
        end
    end

    // Centre emits when its right neighbour arrives, or on the flush after a line end.
    assign w_emit = r_flush || (r_vld_pipe[1] && r_c_vld);
    assign w_r    = r_flush ? 1'b0 : r2_raw;

    always_comb begin
        w_mask = r_c_raw;
        case (r_c_mode)
            2'b00:   w_mask = r_c_raw;
            2'b01:   w_mask = r_l_raw & r_c_raw & w_r;
            2'b10:   w_mask = r_l_raw | r_c_raw | w_r;
            default: w_mask = (r_l_raw & r_c_raw) | (r_l_raw & w_r) | (r_c_raw & w_r);
        endcase
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            r_c_vld <= 1'b0; r_l_raw <= 1'b0; r_c_raw <= 1'b0; r_flush <= 1'b0;
            r_c_pix <= '0; r_c_h <= '0; r_c_v <= '0; r_c_mode <= '0;
        end else if (r_flush) begin
            r_flush <= 1'b0;
            r_c_vld <= 1'b0;
            r_l_raw <= 1'b0;
            r_c_raw <= 1'b0;
        end else if (r_vld_pipe[1]) begin
            r_l_raw  <= (r2_h == '0) ? 1'b0 : r_c_raw;
            r_c_raw  <= r2_raw;
            r_c_pix  <= r2_pix;
            r_c_h    <= r2_h;
            r_c_v    <= r2_v;
            r_c_mode <= r2_mode;
            r_c_vld  <= 1'b1;
            r_flush  <= (r2_h == H_LAST);
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            valid_out  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            pixel_out  <= '0;
            mask_out   <= 1'b0;
        end else begin
            valid_out <= w_emit;
            if (w_emit) begin
                hcount_out <= r_c_h;
                vcount_out <= r_c_v;
                pixel_out  <= r_c_pix;
                mask_out   <= w_mask;
            end
        end
    end
endmodule

// File: tb/tb_mask_filter_stage.sv
// Directed bench for mask_filter_stage on a 6-pixel line; expected masks computed by hand.
module tb_mask_filter_stage;
    localparam int HA = 6;
    localparam int HW = 11;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          rst_in, valid_in;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;
    logic [23:0]   pixel_in;
    logic [1:0]    channel_sel_in, filter_mode_in;
    logic [7:0]    lower_in, upper_in;
    logic          valid_out, mask_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic [23:0]   pixel_out;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    int          out_h[$], out_v[$], out_cyc[$];
    logic [23:0] out_pix[$];
    logic        out_m[$];
    int          in_cyc[HA];
    logic [23:0] pix_tab[HA];

    mask_filter_stage #(.H_ACTIVE(HA), .HCOUNT_W(HW), .VCOUNT_W(VW)) dut (
        .clk_pixel(clk), .rst_in(rst_in), .valid_in(valid_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .channel_sel_in(channel_sel_in), .lower_in(lower_in), .upper_in(upper_in),
        .filter_mode_in(filter_mode_in), .valid_out(valid_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .pixel_out(pixel_out), .mask_out(mask_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            out_h.push_back(int'(hcount_out));
            out_v.push_back(int'(vcount_out));
            out_pix.push_back(pixel_out);
            out_m.push_back(mask_out);
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic beat(input int h, input int v, input logic [23:0] p);
        @(posedge clk); #1;
        valid_in  = 1'b1;
        hcount_in = HW'(h);
        vcount_in = VW'(v);
        pixel_in  = p;
        in_cyc[h] = cyc;
    endtask

    task automatic run_line(input int v, input bit gap);
        int t;
        out_h.delete(); out_v.delete(); out_pix.delete(); out_m.delete(); out_cyc.delete();
        for (int i = 0; i < HA; i++) begin
            beat(i, v, pix_tab[i]);
            if (gap) idle(1);
        end
        idle(2);
        t = 0;
        while (out_h.size() < HA && t < 20) begin
            idle(1);
            t++;
        end
        idle(3);
    endtask

    task automatic set_g_pattern(input logic [HA-1:0] bits);
        for (int i = 0; i < HA; i++) pix_tab[i] = bits[i] ? 24'h00C800 : 24'h000000;
    endtask

    task automatic test_reset;
        logic [HA-1:0] em;
        rst_in = 1'b1; valid_in = 1'b0; hcount_in = '0; vcount_in = '0; pixel_in = '0;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd129; filter_mode_in = 2'b10;
        repeat (3) @(posedge clk);
        #2;
        tot_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else pass_cnt++;
        tot_cnt++; if (pixel_out !== 24'h0) $display("FAIL reset_pixel: got %h want 0", pixel_out); else pass_cnt++;
        tot_cnt++; if (mask_out !== 1'b0) $display("FAIL reset_mask: got %b want 0", mask_out); else pass_cnt++;
        tot_cnt++; if (hcount_out !== '0) $display("FAIL reset_hcount: got %0d want 0", hcount_out); else pass_cnt++;
        @(posedge clk); #1; rst_in = 1'b0;
        // No frame start yet: defaults (R channel, 0..255, bypass) give all ones.
        set_g_pattern(6'b010110);
        run_line(1, 1'b0);
        em = 6'b111111;
        tot_cnt++; if (out_h.size() !== HA) $display("FAIL default_count: got %0d want %0d", out_h.size(), HA); else pass_cnt++;
        for (int i = 0; i < HA && i < out_h.size(); i++) begin
            tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL default_mask[%0d]: got %b want %b", i, out_m[i], em[i]); else pass_cnt++;
        end
    endtask

    task automatic test_luma;
        logic [HA-1:0] em;
        channel_sel_in = 2'b11; lower_in = 8'd100; upper_in = 8'd200; filter_mode_in = 2'b00;
        pix_tab[0] = 24'h808080; pix_tab[1] = 24'hFF0000; pix_tab[2] = 24'h00FF00;
        pix_tab[3] = 24'hC8C8C8; pix_tab[4] = 24'hFFFFFF; pix_tab[5] = 24'h646464;
        em = 6'b101101;
        run_line(0, 1'b0);
        tot_cnt++; if (out_h.size() !== HA) $display("FAIL luma_count: got %0d want %0d", out_h.size(), HA); else pass_cnt++;
        for (int i = 0; i < HA && i < out_h.size(); i++) begin
            tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL luma_mask[%0d]: got %b want %b", i, out_m[i], em[i]); else pass_cnt++;
            tot_cnt++; if (out_pix[i] !== pix_tab[i]) $display("FAIL luma_pixel[%0d]: got %h want %h", i, out_pix[i], pix_tab[i]); else pass_cnt++;
            tot_cnt++; if (out_h[i] !== i) $display("FAIL luma_hcount[%0d]: got %0d want %0d", i, out_h[i], i); else pass_cnt++;
            tot_cnt++; if (out_v[i] !== 0) $display("FAIL luma_vcount[%0d]: got %0d want 0", i, out_v[i]); else pass_cnt++;
            tot_cnt++; if (out_cyc[i] !== in_cyc[i] + 4) $display("FAIL luma_latency[%0d]: got %0d want %0d", i, out_cyc[i], in_cyc[i] + 4); else pass_cnt++;
        end
    endtask

    task automatic test_filters;
        logic [HA-1:0] em;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd255;
        set_g_pattern(6'b010110);
        for (int m = 1; m <= 3; m++) begin
            filter_mode_in = 2'(m);
            em = (m == 1) ? 6'b000000 : (m == 2) ? 6'b111111 : 6'b001110;
            run_line(0, 1'b0);
            tot_cnt++; if (out_h.size() !== HA) $display("FAIL filt%0d_count: got %0d want %0d", m, out_h.size(), HA); else pass_cnt++;
            for (int i = 0; i < HA && i < out_h.size(); i++) begin
                tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL filt%0d_mask[%0d]: got %b want %b", m, i, out_m[i], em[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_edge;
        logic [HA-1:0] em;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd255; filter_mode_in = 2'b01;
        set_g_pattern(6'b111111);
        em = 6'b011110;
        run_line(0, 1'b0);
        tot_cnt++; if (out_h.size() !== HA) $display("FAIL edge_count: got %0d want %0d", out_h.size(), HA); else pass_cnt++;
        for (int i = 0; i < HA && i < out_h.size(); i++) begin
            tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL edge_mask[%0d]: got %b want %b", i, out_m[i], em[i]); else pass_cnt++;
        end
        if (out_h.size() == HA) begin
            tot_cnt++; if (out_cyc[HA-1] !== out_cyc[HA-2] + 1) $display("FAIL edge_flush_gap: got %0d want %0d", out_cyc[HA-1], out_cyc[HA-2] + 1); else pass_cnt++;
            tot_cnt++; if (out_cyc[HA-1] !== in_cyc[HA-1] + 4) $display("FAIL edge_last_latency: got %0d want %0d", out_cyc[HA-1], in_cyc[HA-1] + 4); else pass_cnt++;
        end
    endtask

    task automatic test_gaps;
        logic [HA-1:0] em;
        int want;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd255; filter_mode_in = 2'b11;
        set_g_pattern(6'b010110);
        em = 6'b001110;
        run_line(0, 1'b1);
        tot_cnt++; if (out_h.size() !== HA) $display("FAIL gap_count: got %0d want %0d", out_h.size(), HA); else pass_cnt++;
        for (int i = 0; i < HA && i < out_h.size(); i++) begin
            want = (i == HA - 1) ? in_cyc[i] + 4 : in_cyc[i+1] + 3;
            tot_cnt++; if (out_h[i] !== i) $display("FAIL gap_hcount[%0d]: got %0d want %0d", i, out_h[i], i); else pass_cnt++;
            tot_cnt++; if (out_pix[i] !== pix_tab[i]) $display("FAIL gap_pixel[%0d]: got %h want %h", i, out_pix[i], pix_tab[i]); else pass_cnt++;
            tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL gap_mask[%0d]: got %b want %b", i, out_m[i], em[i]); else pass_cnt++;
            tot_cnt++; if (out_cyc[i] !== want) $display("FAIL gap_latency[%0d]: got %0d want %0d", i, out_cyc[i], want); else pass_cnt++;
        end
    endtask

    task automatic test_config;
        logic [HA-1:0] em;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd255; filter_mode_in = 2'b00;
        set_g_pattern(6'b010110);
        run_line(0, 1'b0);
        upper_in = 8'd50;
        lower_in = 8'd0;
        for (int step = 0; step < 3; step++) begin
            if (step == 0) begin run_line(1, 1'b0); em = 6'b010110; end
            else if (step == 1) begin run_line(0, 1'b0); em = 6'b101001; end
            else begin lower_in = 8'd60; run_line(0, 1'b0); em = 6'b000000; end
            tot_cnt++; if (out_h.size() !== HA) $display("FAIL cfg%0d_count: got %0d want %0d", step, out_h.size(), HA); else pass_cnt++;
            for (int i = 0; i < HA && i < out_h.size(); i++) begin
                tot_cnt++; if (out_m[i] !== em[i]) $display("FAIL cfg%0d_mask[%0d]: got %b want %b", step, i, out_m[i], em[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_midline;
        channel_sel_in = 2'b01; lower_in = 8'd128; upper_in = 8'd255; filter_mode_in = 2'b00;
        set_g_pattern(6'b111111);
        beat(0, 0, pix_tab[0]);
        beat(1, 0, pix_tab[1]);
        beat(2, 0, pix_tab[2]);
        idle(2);
        // Pixel 0 is on the outputs now; pixels 1 and 2 are still in flight.
        tot_cnt++; if (valid_out !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", valid_out); else pass_cnt++;
        tot_cnt++; if (pixel_out !== 24'h00C800) $display("FAIL mid_pre_pixel: got %h want 00c800", pixel_out); else pass_cnt++;
        tot_cnt++; if (mask_out !== 1'b1) $display("FAIL mid_pre_mask: got %b want 1", mask_out); else pass_cnt++;
        #1; rst_in = 1'b1;
        #1;
        tot_cnt++; if (valid_out !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", valid_out); else pass_cnt++;
        tot_cnt++; if (pixel_out !== 24'h0) $display("FAIL mid_rst_pixel: got %h want 0", pixel_out); else pass_cnt++;
        tot_cnt++; if (mask_out !== 1'b0) $display("FAIL mid_rst_mask: got %b want 0", mask_out); else pass_cnt++;
        out_h.delete(); out_v.delete(); out_pix.delete(); out_m.delete(); out_cyc.delete();
        @(posedge clk); #1; rst_in = 1'b0;
        idle(10);
        tot_cnt++; if (out_h.size() !== 0) $display("FAIL mid_no_output: got %0d beats want 0", out_h.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_luma();
        test_filters();
        test_edge();
        test_gaps();
        test_config();
        test_reset_midline();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/mask_filter_stage.md
Name: mask_filter_stage

Overview:
- Upstream neighbour of the video mux: converts a 24-bit RGB camera stream into a 1-bit threshold mask, with optional 3-tap horizontal morphological cleanup.
- Delivers the mask together with the delay-matched camera pixel and coordinates, so the mux can overlay mask on image with no further alignment.
- Config is shadowed at frame start so switches never tear mid-frame.

Parameters:
- H_ACTIVE, 1280, active pixels per line; hcount_in == H_ACTIVE-1 marks the last pixel of a line.
- HCOUNT_W, 11, width of hcount ports.
- VCOUNT_W, 10, width of vcount ports.

Ports:
- clk_pixel  input  1  pixel clock.
- rst_in  input  1  asynchronous active-high reset.
- valid_in  input  1  pixel_in/hcount_in/vcount_in valid this cycle.
- hcount_in  input  HCOUNT_W  pixel x.
- vcount_in  input  VCOUNT_W  pixel y.
- pixel_in  input  24  RGB 8:8:8, R in [23:16].
- channel_sel_in  input  2  00 R, 01 G, 10 B, 11 luma.
- lower_in  input  8  inclusive lower threshold.
- upper_in  input  8  inclusive upper threshold.
- filter_mode_in  input  2  00 bypass, 01 erode, 10 dilate, 11 majority.
- valid_out  output  1  outputs valid.
- hcount_out  output  HCOUNT_W  x of emitted pixel.
- vcount_out  output  VCOUNT_W  y of emitted pixel.
- pixel_out  output  24  camera pixel, unmodified, aligned with mask_out.
- mask_out  output  1  filtered threshold bit.

Behaviour:
- Reset: async assert clears all valid bits, data registers, and outputs to 0. Shadow config resets to channel 00, lower 0, upper 255, mode 00.
- Shadow config: channel/lower/upper/mode are captured only on a beat with valid_in=1, hcount_in=0, vcount_in=0. That beat and all later beats use the new values. Config changes at any other time have no effect until the next frame start.
- Stage 1 (registered): pixel, coords, valid; select channel value.
- Luma = (77*R + 150*G + 29*B) >> 8, 16-bit intermediate, result 8-bit, no rounding.
- Stage 2 (registered): raw = (lower <= ch) && (ch <= upper), unsigned compare. If lower > upper, raw = 0 for every pixel.
- Window stage: shifts only on stage-2 valid beats. Holds left (L) and centre (C) raw bits, plus C's pixel and coords.
- Pixel x is emitted when x+1's raw bit arrives, using R = x+1's bit.
- Left-edge rule: L = 0 when C has hcount 0.
- Right-edge rule: when the stage-2 beat carries hcount H_ACTIVE-1, the cycle proceeds as follows.
  - Emit the pending centre x-1 that cycle.
  - Emit pixel H_ACTIVE-1 in the following cycle (flush) with R = 0.
  - Then clear the window.
- Filter: bypass mask = C; erode = L&C&R; dilate = L|C|R; majority = at least 2 of 3.
- Outputs are registered. valid_out is high for exactly one cycle per emitted pixel.
- Latency: a non-last pixel x is emitted 3 cycles after x+1's valid_in; the last pixel of a line is emitted 4 cycles after its own valid_in. With continuous valid_in, every pixel's outputs appear exactly 4 cycles after its valid_in, one per cycle, in order.
- Gaps: valid_in may be deasserted between any beats within a line (e.g. every other cycle). Ordering and pixel/mask pairing are preserved.
- Input contract: at least 2 invalid cycles between hcount H_ACTIVE-1 and the next line's hcount 0. hcount is strictly increasing within a line. Violation behaviour is unspecified.
- Reset mid-line: in-flight pixels are discarded and no flush beat is generated. Config stays at defaults until the next frame-start beat.

Test Plan:
- Reset, then continuous frame with channel 11, lower 100, upper 200, mode 00. Pixel 0x808080 → Y=128, mask_out=1. Pixel 0xFF0000 → Y=76, mask_out=0. valid_out exactly 4 cycles after each valid_in.
- Line raw pattern 0,1,1,0,1,0 (G channel, thresholds 128..255):
  - erode → 0,0,0,0,0,0
  - dilate → 1,1,1,1,1,1
  - majority → 0,1,1,1,0,0
- Edge handling, H_ACTIVE=4, raw 1,1,1,1, erode → 0,1,1,0. The last pixel is output one cycle after pixel 2's output and 4 cycles after its own valid_in.
- valid_in every other cycle: hcount_out/pixel_out/mask_out match a continuous-valid golden model; each non-last pixel is emitted 3 cycles after the next pixel's valid_in.
- Frame-start config:
  - Change upper from 255 to 50 mid-frame → masks for the rest of that frame unchanged.
  - Change takes effect from pixel (0,0) of the next frame.
  - lower 60 > upper 50 → all mask_out=0.
- Assert rst_in for 1 cycle mid-line with 2 pixels in flight → valid_out, pixel_out and mask_out go to 0 immediately. No output for the in-flight pixels and no flush beat.
